if_id_fetch_unit: RTL and testbench
===================================

Name: if_id_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction memory.
- Holds the 64-bit PC, drives the fetch address to the memory, and captures the returned 32-bit instruction into the IF/ID pipeline register for decode.
- Handles stalls, branch/jump redirects (flushes), misaligned redirect targets, and running off the end of instruction memory.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 132, size of the instruction memory in bytes; the last legal fetch address is IMEM_BYTES-4.
- NOP_INST, 32'h00000013, instruction (addi x0,x0,0) inserted as a bubble.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from decode; hold PC and IF/ID.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_target  input  64  new PC when redirect_valid=1.
- inst_addr  output  64  fetch byte address to instruction memory; always equals the PC register.
- inst_data  input  32  combinational instruction returned for inst_addr.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  64  PC of the instruction in IF/ID.
- id_pc_plus4  output  64  id_pc+4.
- id_instruction  output  32  instruction in IF/ID; NOP_INST when id_valid=0.
- halted  output  1  fetch stopped (END or FAULT state).
- misalign_fault  output  1  sticky; set by a redirect target with bits[1:0] not 00.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1), overrides everything:
  - pc=RESET_PC, state=BOOT.
  - id_valid=0, id_instruction=NOP_INST, id_pc=0, id_pc_plus4=4.
  - halted=0, misalign_fault=0.
- States: BOOT, RUN, END, FAULT.
- BOOT: one cycle. IF/ID loads a bubble; pc is unchanged; go to RUN. This gives memory one cycle to settle after reset.
- RUN, per edge, evaluated in this priority order:
  1. redirect_valid=1, target[1:0]!=0: misalign_fault=1, IF/ID loads a bubble, state=FAULT, pc unchanged.
  2. redirect_valid=1, aligned target: pc=redirect_target; IF/ID loads a bubble (flush). The redirect overrides stall.
  3. stall=1: pc and IF/ID hold their values.
  4. pc > IMEM_BYTES-4: IF/ID loads a bubble, state=END, pc held.
  5. Otherwise: IF/ID loads {valid=1, pc, pc+4, inst_data}; pc=pc+4.
- PC arithmetic is 64-bit unsigned and wraps modulo 2^64. A wrapped PC of 0 is fetched normally.
- END: halted=1; IF/ID holds a bubble.
  - An aligned redirect with target <= IMEM_BYTES-4 loads pc and returns to RUN; IF/ID is a bubble that cycle.
  - stall is ignored in END.
- FAULT: halted=1; IF/ID holds a bubble. Only reset leaves FAULT.
- Latency: an instruction at address A appears in IF/ID one edge after pc==A with no stall or redirect. A redirect costs exactly one bubble.
- Reset in mid-operation (stall, redirect, or END active): reset wins, and the reset values above apply on that edge.
- The fetch address is combinational from the pc register; no other output is combinational.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, the block adds two output ports:
  - fetch_count[31:0]: increments on every RUN-state load with valid=1.
  - bubble_count[31:0]: increments on every edge where IF/ID loads a bubble (BOOT, flush, END entry, FAULT entry).
  - Both counters clear on reset, saturate at 32'hFFFFFFFF, and hold while stall=1.
- When undefined, neither the ports nor the counter logic exist, and all other behaviour is identical.

Test Plan:
- Straight-line fetch: reset, then run with stall=0. Expect edge 1 = bubble (BOOT); edge 2 gives id_pc=0, id_instruction=inst_data@0 (e.g. 32'h00A00293), id_valid=1; edge 3 gives id_pc=4, id_pc_plus4=8.
- Stall: at pc=8, hold stall=1 for 3 cycles. Expect inst_addr=8 and IF/ID frozen at id_pc=4 throughout; on release the next load is id_pc=8.
- Flush: at pc=0x40, assert redirect_valid with target 0x38, together with stall=1. Expect the next edge to give id_valid=0, id_instruction=0x00000013, inst_addr=0x38; the edge after gives id_pc=0x38, id_valid=1.
- End of memory: run to pc=128 (fetched), then pc=132. Expect halted=1, id_valid=0, state END. An aligned redirect to 0x20 then gives halted=0, with id_pc=0x20 valid two edges later.
- Misaligned redirect: target 0x22. Expect misalign_fault=1, halted=1, bubbles thereafter. Redirect to 0x20 is ignored; only reset clears the fault.
- With FETCH_PERF_EN, after the straight-line test from reset to END: fetch_count=33, bubble_count=2; reset asserted at any point clears both counters to 0.

Source files
------------

// File: rtl/if_id_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_id_fetch_unit_if
// Bus between the fetch unit and its neighbours: the instruction memory, the
// decode stage (stall input, IF/ID outputs) and execute (redirect).
//   master : the fetch unit (drives inst_addr and the IF/ID register outputs)
//   slave  : the surroundings (drive stall, redirect, inst_data)
// Signals:
//   stall           hazard stall from decode
//   redirect_valid  taken branch/jump from execute
//   redirect_target new PC when redirect_valid=1
//   inst_addr       fetch byte address (equals the PC register)
//   inst_data       instruction returned combinationally for inst_addr
//   id_valid/id_pc/id_pc_plus4/id_instruction  IF/ID pipeline register
//   halted          fetch stopped (end of memory or fault)
//   misalign_fault  sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
interface if_id_fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] inst_addr;
    logic [31:0] inst_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;
    logic [31:0] id_instruction;
    logic        halted;
    logic        misalign_fault;

    modport master (
        input  stall, redirect_valid, redirect_target, inst_data,
        output inst_addr, id_valid, id_pc, id_pc_plus4, id_instruction,
               halted, misalign_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_target, inst_data,
        input  inst_addr, id_valid, id_pc, id_pc_plus4, id_instruction,
               halted, misalign_fault
    );
endinterface

// File: rtl/if_id_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_id_fetch_unit
// Instruction fetch stage: holds the 64-bit PC, presents it to instruction
// memory and captures the returned word into the IF/ID register.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    if_id_fetch_unit_if.master (stall, redirect, memory, IF/ID outputs)
//   fetch_count, bubble_count  (only with FETCH_PERF_EN) saturating counters
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module if_id_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 132,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    if_id_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`endif
);

    localparam logic [63:0] LAST_ADDR = 64'(IMEM_BYTES) - 64'd4;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_END, S_FAULT} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic        load_bubble;
    logic        load_inst;
    logic        fault_set;

    assign bus.inst_addr = pc;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        load_bubble = 1'b0;
        load_inst   = 1'b0;
        fault_set   = 1'b0;
        case (state)
            // One settling cycle for memory after reset.
            S_BOOT: begin
                load_bubble = 1'b1;
                state_next  = S_RUN;
            end
            S_RUN: begin
                if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) begin
                    fault_set   = 1'b1;
                    load_bubble = 1'b1;
                    state_next  = S_FAULT;
                end else if (bus.redirect_valid) begin
                    // Redirect wins over stall: the flushed slot becomes a bubble.
                    pc_next     = bus.redirect_target;
                    load_bubble = 1'b1;
                end else if (bus.stall) begin
                    // hold pc and IF/ID
                end else if (pc > LAST_ADDR) begin
                    load_bubble = 1'b1;
                    state_next  = S_END;
                end else begin
                    load_inst = 1'b1;
                    pc_next   = pc + 64'd4;
                end
            end
            S_END: begin
                // Only an aligned, in-range redirect restarts fetch; stall is ignored.
                if (bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00) &&
                    (bus.redirect_target <= LAST_ADDR)) begin
                    pc_next     = bus.redirect_target;
                    load_bubble = 1'b1;
                    state_next  = S_RUN;
                end
            end
            default: begin
                // S_FAULT: only reset leaves
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc                 <= RESET_PC;
            state              <= S_BOOT;
            bus.id_valid       <= 1'b0;
            bus.id_instruction <= NOP_INST;
            bus.id_pc          <= 64'd0;
            bus.id_pc_plus4    <= 64'd4;
            bus.halted         <= 1'b0;
            bus.misalign_fault <= 1'b0;
        end else begin
            pc         <= pc_next;
            state      <= state_next;
            // Registered copy of "stopped" so halted is not a decode of state.
            bus.halted <= (state_next == S_END) || (state_next == S_FAULT);
            if (fault_set) begin
                bus.misalign_fault <= 1'b1;
            end
            if (load_bubble) begin
                bus.id_valid       <= 1'b0;
                bus.id_instruction <= NOP_INST;
                bus.id_pc          <= 64'd0;
                bus.id_pc_plus4    <= 64'd4;
            end else if (load_inst) begin
                bus.id_valid       <= 1'b1;
                bus.id_instruction <= bus.inst_data;
                bus.id_pc          <= pc;
                bus.id_pc_plus4    <= pc + 64'd4;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else if (!bus.stall) begin
            if (load_inst && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (load_bubble && (bubble_count != 32'hFFFF_FFFF)) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_unit
// Directed walk through the fetch scenarios followed by random stall /
// redirect / reset traffic. A behavioural model of the fetch stage runs on
// each clock edge; a negedge process compares every DUT output against it.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_unit;
    localparam logic [63:0] LAST = 64'd128;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam int M_BOOT = 0, M_RUN = 1, M_END = 2, M_FAULT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_id_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, bubble_count;
    if_id_fetch_unit dut (.clk(clk), .reset(rst), .bus(bus),
                          .fetch_count(fetch_count), .bubble_count(bubble_count));
`else
    if_id_fetch_unit dut (.clk(clk), .reset(rst), .bus(bus));
`endif

    // Instruction memory image; out-of-range reads return garbage.
    logic [31:0] mem [0:63];
    assign bus.inst_data = (bus.inst_addr <= LAST) ? mem[bus.inst_addr[7:2]] : 32'hDEADBEEF;

    // Behavioural model
    int          m_mode;
    logic [63:0] m_pc;
    logic        m_valid, m_fault;
    logic [63:0] m_ipc;
    logic [31:0] m_inst;
    longint unsigned m_fc, m_bc;

    int n_run  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h want %h @%0t", n, act, exp, $time);
        end
    endtask

    function automatic void m_bubble(input bit cnt);
        m_valid = 1'b0;
        m_inst  = NOP;
        if (cnt && m_bc < 64'hFFFF_FFFF) m_bc++;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit rv, input logic [63:0] rt);
        if (r) begin
            m_pc = 64'd0; m_mode = M_BOOT; m_valid = 1'b0; m_inst = NOP;
            m_ipc = 64'd0; m_fault = 1'b0; m_fc = 0; m_bc = 0;
        end else begin
            case (m_mode)
                M_BOOT: begin m_bubble(!s); m_mode = M_RUN; end
                M_RUN: begin
                    if (rv && rt[1:0] != 2'b00) begin
                        m_fault = 1'b1; m_bubble(!s); m_mode = M_FAULT;
                    end else if (rv) begin
                        m_pc = rt; m_bubble(!s);
                    end else if (s) begin
                    end else if (m_pc > LAST) begin
                        m_bubble(1'b1); m_mode = M_END;
                    end else begin
                        m_valid = 1'b1; m_ipc = m_pc; m_inst = mem[m_pc[7:2]];
                        m_pc = m_pc + 64'd4;
                        if (m_fc < 64'hFFFF_FFFF) m_fc++;
                    end
                end
                M_END: begin
                    if (rv && rt[1:0] == 2'b00 && rt <= LAST) begin
                        m_pc = rt; m_bubble(!s); m_mode = M_RUN;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit rv, input logic [63:0] rt);
        rst = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = rt;
        @(posedge clk);
        model_edge(r, s, rv, rt);
        @(negedge clk);
    endtask

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("inst_addr", bus.inst_addr, m_pc);
            chk("id_valid", 64'(bus.id_valid), 64'(m_valid));
            chk("id_instruction", 64'(bus.id_instruction), 64'(m_inst));
            if (m_valid) begin
                chk("id_pc", bus.id_pc, m_ipc);
                chk("id_pc_plus4", bus.id_pc_plus4, m_ipc + 64'd4);
            end
            chk("halted", 64'(bus.halted), 64'(m_mode == M_END || m_mode == M_FAULT));
            chk("misalign_fault", 64'(bus.misalign_fault), 64'(m_fault));
`ifdef FETCH_PERF_EN
            chk("fetch_count", 64'(fetch_count), m_fc);
            chk("bubble_count", 64'(bubble_count), m_bc);
`endif
        end
    end

    initial begin
        logic [63:0] rt;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 64'd0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00A00293;
        @(negedge clk);

        // Reset values
        cyc(1, 0, 0, 0);
        chk_en = 1;
        chk("rst id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst id_instruction", 64'(bus.id_instruction), 64'h13);
        chk("rst id_pc", bus.id_pc, 64'd0);
        chk("rst id_pc_plus4", bus.id_pc_plus4, 64'd4);
        chk("rst inst_addr", bus.inst_addr, 64'd0);
        chk("rst halted", 64'(bus.halted), 64'd0);

        // Straight-line fetch
        cyc(0, 0, 0, 0);
        chk("boot bubble", 64'(bus.id_valid), 64'd0);
        cyc(0, 0, 0, 0);
        chk("first id_valid", 64'(bus.id_valid), 64'd1);
        chk("first id_pc", bus.id_pc, 64'd0);
        chk("first inst", 64'(bus.id_instruction), 64'h00A00293);
        cyc(0, 0, 0, 0);
        chk("second id_pc", bus.id_pc, 64'd4);
        chk("second id_pc_plus4", bus.id_pc_plus4, 64'd8);

        // Stall at pc=8
        repeat (3) begin
            cyc(0, 1, 0, 0);
            chk("stall inst_addr", bus.inst_addr, 64'd8);
            chk("stall id_pc", bus.id_pc, 64'd4);
        end
        cyc(0, 0, 0, 0);
        chk("unstall id_pc", bus.id_pc, 64'd8);

        // Flush at pc=0x40 with stall also high
        repeat (13) cyc(0, 0, 0, 0);
        chk("pre-flush addr", bus.inst_addr, 64'h40);
        cyc(0, 1, 1, 64'h38);
        chk("flush id_valid", 64'(bus.id_valid), 64'd0);
        chk("flush inst", 64'(bus.id_instruction), 64'h13);
        chk("flush addr", bus.inst_addr, 64'h38);
        cyc(0, 0, 0, 0);
        chk("post-flush id_pc", bus.id_pc, 64'h38);
        chk("post-flush valid", 64'(bus.id_valid), 64'd1);

        // End of memory
        repeat (18) cyc(0, 0, 0, 0);
        chk("last id_pc", bus.id_pc, 64'd128);
        chk("last halted", 64'(bus.halted), 64'd0);
        cyc(0, 0, 0, 0);
        chk("end halted", 64'(bus.halted), 64'd1);
        chk("end id_valid", 64'(bus.id_valid), 64'd0);
        cyc(0, 1, 0, 0);
        chk("end stall ignored halted", 64'(bus.halted), 64'd1);
        cyc(0, 0, 1, 64'h20);
        chk("restart halted", 64'(bus.halted), 64'd0);
        chk("restart addr", bus.inst_addr, 64'h20);
        cyc(0, 0, 0, 0);
        chk("restart id_pc", bus.id_pc, 64'h20);
        chk("restart valid", 64'(bus.id_valid), 64'd1);

        // Misaligned redirect
        cyc(0, 0, 1, 64'h22);
        chk("mis fault", 64'(bus.misalign_fault), 64'd1);
        chk("mis halted", 64'(bus.halted), 64'd1);
        cyc(0, 0, 1, 64'h20);
        chk("fault ignores redirect", bus.inst_addr, 64'h24);
        chk("fault bubble", 64'(bus.id_valid), 64'd0);
        cyc(1, 0, 0, 0);
        chk("reset clears fault", 64'(bus.misalign_fault), 64'd0);

        // Full straight run from reset to END
        repeat (35) cyc(0, 0, 0, 0);
        chk("straight halted", 64'(bus.halted), 64'd1);
`ifdef FETCH_PERF_EN
        chk("straight fetch_count", 64'(fetch_count), 64'd33);
        chk("straight bubble_count", 64'(bubble_count), 64'd2);
        cyc(1, 0, 0, 0);
        chk("reset fetch_count", 64'(fetch_count), 64'd0);
`endif

        // Random traffic
        cyc(1, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 9))
                0:       rt = {$urandom, $urandom};
                1:       rt = 64'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
                2:       rt = 64'hFFFF_FFFF_FFFF_FFFC;
                default: rt = 64'($urandom_range(0, 40) * 4);
            endcase
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), rt);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
